// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute controller driving the ALU, register file and memory
module cpu_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  input  logic [15:0] ra_data,
  input  logic [15:0] rb_data,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [7:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic [15:0] pc,
  output logic        illegal
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, MEM} state_e;
  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, pc_inc;
  logic [4:0]  psr_q, psr_d;
  logic        ill_q, ill_d;
  logic [3:0]  op, ext, cond, code;
  logic        r_alu, i_alu, s_reg, s_imm, alu_op, flag_upd, cmp;
  logic        ld, st, jc, jal, bc, taken, legal;
  logic [15:0] cond_vec;
  function automatic logic alu_code(input logic [3:0] k);
    return k inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hF};
  endfunction
  assign op         = ir_q[15:12];
  assign ext        = ir_q[7:4];
  assign cond       = ir_q[11:8];
  assign code       = (op == 4'h0) ? ext : op;
  assign r_alu      = (op == 4'h0) && alu_code(ext);
  assign i_alu      = alu_code(op);
  assign s_reg      = (op == 4'h8) && (ext == 4'h4 || ext == 4'h6);
  assign s_imm      = (op == 4'h8) && (ext[3:2] == 2'b00);
  assign alu_op     = r_alu | i_alu | s_reg | s_imm;
  assign flag_upd   = (r_alu | i_alu) && (code inside {4'h1, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB});
  assign cmp        = (r_alu | i_alu) && (code == 4'hB);
  assign ld         = (op == 4'h4) && (ext == 4'h0);
  assign st         = (op == 4'h4) && (ext == 4'h4);
  assign jc         = (op == 4'h4) && (ext == 4'hC);
  assign jal        = (op == 4'h4) && (ext == 4'h8);
  assign bc         = (op == 4'hC);
  assign legal      = alu_op | ld | st | jc | jal | bc;
  // psr bit order {C,L,F,Z,N}; vector indexed by cond code
  assign cond_vec   = {1'b0, 1'b1, psr_q[0] | psr_q[1], !psr_q[0] & !psr_q[1],
                       psr_q[3] | psr_q[1], !psr_q[3] & !psr_q[1], !psr_q[2], psr_q[2],
                       !psr_q[0], psr_q[0], !psr_q[3], psr_q[3],
                       !psr_q[4], psr_q[4], !psr_q[1], psr_q[1]};
  assign taken      = cond_vec[cond];
  assign pc_inc     = pc_q + 16'd1;
  assign ra_addr    = ir_q[11:8];
  assign rb_addr    = ir_q[3:0];
  assign rf_waddr   = ir_q[11:8];
  assign mem_wdata  = ra_data;
  assign alu_opcode = {op, ext};
  assign alu_a      = ra_data;
  assign alu_b      = (i_alu | s_imm) ? {8'h00, ir_q[7:0]} : rb_data;
  assign psr        = psr_q;
  assign pc         = pc_q;
  assign illegal    = ill_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      psr_q   <= 5'h00;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
      ill_q   <= ill_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    psr_d    = psr_q;
    ill_d    = ill_q;
    mem_addr = pc_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_c;
    case (state_q)
      FETCH: begin
        mem_rd  = run;
        state_d = run ? DECODE : FETCH;
      end
      DECODE: begin
        ir_d    = mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        state_d  = ld ? MEM : FETCH;
        rf_we    = (alu_op & !cmp) | jal;
        rf_wdata = jal ? pc_inc : alu_c;
        psr_d    = flag_upd ? alu_flags : psr_q;
        mem_addr = (ld | st) ? rb_data : pc_q;
        mem_rd   = ld;
        mem_wr   = st;
        ill_d    = ill_q | !legal;
        pc_d     = (bc & taken) ? pc_q + {{8{ir_q[7]}}, ir_q[7:0]} :
                   ((jc & taken) | jal) ? rb_data : pc_inc;
      end
      default: begin
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
        state_d  = FETCH;
      end
    endcase
    // an aborted instruction must leave no trace in memory or the register file
    if (reset) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      rf_we  = 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed and random instructions checked against an instruction-level model
module tb_cpu_control_fsm;
  logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, ra_data, rb_data, rf_wdata, alu_a, alu_b, alu_c, pc;
  logic        mem_rd, mem_wr, rf_we, illegal;
  logic [3:0]  ra_addr, rb_addr, rf_waddr;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr;
  logic [15:0] emem [65536];
  logic [15:0] erf  [16];
  logic [15:0] m_mem [65536];
  logic [15:0] m_rf [16];
  logic [15:0] m_pc;
  logic [4:0]  m_psr;
  logic        m_ill;
  int          checks = 0, errors = 0;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign ra_data = erf[ra_addr];
  assign rb_data = erf[rb_addr];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= emem[mem_addr];
    if (mem_wr) emem[mem_addr] <= mem_wdata;
    if (rf_we) erf[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] p);
    logic C, L, F, Z, N;
    {C, L, F, Z, N} = p;
    case (c)
      4'h0: return Z;        4'h1: return !Z;
      4'h2: return C;        4'h3: return !C;
      4'h4: return L;        4'h5: return !L;
      4'h6: return N;        4'h7: return !N;
      4'h8: return F;        4'h9: return !F;
      4'hA: return !L && !Z; 4'hB: return L || Z;
      4'hC: return !N && !Z; 4'hD: return N || Z;
      4'hE: return 1'b1;     default: return 1'b0;
    endcase
  endfunction

  task automatic set_reg(input int i, input logic [15:0] v);
    m_rf[i] = v;
    erf[i] <= v;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    m_mem[a] = v;
    emem[a] <= v;
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Called at negedge+1 while the DUT sits in FETCH; returns at negedge+1 of the next FETCH.
  task automatic do_instr(input logic [15:0] ins, input logic [15:0] c, input logic [4:0] f);
    logic [3:0]  op, rd, ext, rs;
    logic [15:0] a, b, npc, wv, lv;
    logic        we, ld, st, upd, ill, imm;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0];
    a = m_rf[rd]; b = m_rf[rs]; npc = m_pc + 16'd1; wv = c;
    we = 0; ld = 0; st = 0; upd = 0; ill = 0; imm = 0;
    case (op)
      4'h0: begin
        case (ext)
          4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD, 4'hF: we = 1;
          4'hB: we = 0;
          default: ill = 1;
        endcase
        upd = ext inside {4'h1, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB};
      end
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hF: begin
        imm = 1;
        we = (op != 4'hB);
        upd = op inside {4'h1, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB};
      end
      4'h8: begin
        if (ext == 4'h4 || ext == 4'h6) we = 1;
        else if (ext < 4'h4) begin we = 1; imm = 1; end
        else ill = 1;
      end
      4'h4: begin
        case (ext)
          4'h0: ld = 1;
          4'h4: st = 1;
          4'hC: if (cond_ok(rd, m_psr)) npc = b;
          4'h8: begin we = 1; wv = m_pc + 16'd1; npc = b; end
          default: ill = 1;
        endcase
      end
      4'hC: if (cond_ok(rd, m_psr)) npc = m_pc + {{8{ins[7]}}, ins[7:0]};
      default: ill = 1;
    endcase
    set_mem(m_pc, ins);
    alu_c = c; alu_flags = f; run = 1;
    #1;
    check("fetch_rd", mem_rd, 1);
    check("fetch_addr", mem_addr, m_pc);
    check("fetch_wr_we", {mem_wr, rf_we}, 0);
    step;
    check("decode_strobes", {mem_rd, mem_wr, rf_we}, 0);
    step;
    check("exec_opcode", alu_opcode, {op, ext});
    check("exec_a", alu_a, a);
    check("exec_b", alu_b, imm ? {8'h00, ins[7:0]} : b);
    check("exec_we", rf_we, we);
    if (we) begin
      check("exec_waddr", rf_waddr, rd);
      check("exec_wdata", rf_wdata, wv);
    end
    check("exec_rd", mem_rd, ld);
    check("exec_wr", mem_wr, st);
    if (ld | st) check("exec_maddr", mem_addr, b);
    if (st) check("exec_wdata_mem", mem_wdata, a);
    if (we) m_rf[rd] = wv;
    if (st) m_mem[b] = a;
    if (upd) m_psr = f;
    m_ill = m_ill | ill;
    m_pc = npc;
    step;
    if (ld) begin
      lv = m_mem[b];
      check("mem_we", rf_we, 1);
      check("mem_waddr", rf_waddr, rd);
      check("mem_wdata", rf_wdata, lv);
      check("mem_strobes", {mem_rd, mem_wr}, 0);
      m_rf[rd] = lv;
      step;
    end
    check("pc", pc, m_pc);
    check("psr", psr, m_psr);
    check("illegal", illegal, m_ill);
  endtask

  initial begin
    logic [15:0] ins;
    for (int i = 0; i < 65536; i++) begin emem[i] = 16'h0000; m_mem[i] = 16'h0000; end
    for (int i = 0; i < 16; i++) begin m_rf[i] = 16'($urandom); erf[i] = m_rf[i]; end
    alu_c = 0; alu_flags = 0;
    m_pc = 16'h0000; m_psr = 0; m_ill = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_psr", psr, 0);
    check("rst_ill", illegal, 0);
    check("rst_strobes", {mem_rd, mem_wr, rf_we}, 0);
    reset = 0;
    // ADD R1,R2
    set_reg(1, 16'd5); set_reg(2, 16'd7);
    do_instr(16'h0152, 16'd12, 5'b01000);
    // CMPI then conditional branches around pc 5
    set_reg(3, 16'h0010);
    do_instr(16'hB310, 16'h0000, 5'b00010);
    repeat (3) do_instr(16'hD000, 16'($urandom), 5'($urandom));
    do_instr(16'hC0FE, 16'($urandom), 5'($urandom));
    check("beq_taken_pc", pc, 16'h0003);
    repeat (2) do_instr(16'hD000, 16'($urandom), 5'($urandom));
    do_instr(16'hC1FE, 16'($urandom), 5'($urandom));
    check("bne_not_taken_pc", pc, 16'h0006);
    // LOAD and STOR
    set_reg(4, 16'h0100); set_mem(16'h0100, 16'hBEEF);
    do_instr(16'h4204, 16'($urandom), 5'($urandom));
    set_reg(3, 16'h1234); set_reg(5, 16'h0200);
    do_instr(16'h4345, 16'($urandom), 5'($urandom));
    check("stor_mem", emem[16'h0200], 16'h1234);
    // JAL from 0x0010, then a never-taken branch wrapping pc at 0xFFFF
    set_reg(9, 16'h0010);
    do_instr(16'h4EC9, 16'($urandom), 5'($urandom));
    set_reg(10, 16'h0040);
    do_instr(16'h4E8A, 16'($urandom), 5'($urandom));
    check("jal_pc", pc, 16'h0040);
    set_reg(9, 16'hFFFF);
    do_instr(16'h4EC9, 16'($urandom), 5'($urandom));
    do_instr(16'hCF05, 16'($urandom), 5'($urandom));
    check("wrap_pc", pc, 16'h0000);
    // reset during EXEC of an ADD
    set_mem(m_pc, 16'h0152);
    alu_c = 16'hAAAA; alu_flags = 5'b11111;
    step; step;
    reset = 1;
    #1;
    check("abort_we", rf_we, 0);
    check("abort_mem", {mem_rd, mem_wr}, 0);
    step;
    m_pc = 16'h0000; m_psr = 0; m_ill = 0;
    check("abort_pc", pc, 16'h0000);
    check("abort_psr", psr, 0);
    check("abort_rd", mem_rd, 0);
    reset = 0;
    // undefined encoding, then hold with run low
    do_instr(16'h0000, 16'($urandom), 5'($urandom));
    check("illegal_set", illegal, 1);
    run = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("idle_rd", mem_rd, 0);
      check("idle_pc", pc, m_pc);
      step;
    end
    // random instruction stream
    for (int n = 0; n < 400; n++) begin
      ins = 16'($urandom);
      case ($urandom_range(0, 6))
        1: begin ins[15:12] = 4'h4; ins[7:4] = {2'($urandom), 2'b00}; end
        2: ins[15:12] = 4'hC;
        3: ins[15:12] = 4'h0;
        4: ins[15:12] = 4'h8;
        5: if ($urandom_range(0, 3) == 0) begin set_reg($urandom_range(0, 15), 16'($urandom)); end
        default: ;
      endcase
      do_instr(ins, 16'($urandom), 5'($urandom));
    end
    for (int i = 0; i < 16; i++) check($sformatf("rf%0d", i), erf[i], m_rf[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
